arbitro_roteador: RTL

- Round-robin arbiter and sequencer for the 4-bit 2:1 routing datapath (A/B inputs, SEL, single output).
- Two requesters share the datapath. The block chooses which requester owns it, drives the select, and passes the selected word through a single-entry output register with a valid/ready handshake.
- An optional lock lets the current owner keep the datapath for a bounded burst.
- It sits between the two data sources and the single downstream consumer.

---
 rtl/arbitro_roteador.sv | 103 ++++++++++
 1 files changed

// File: rtl/arbitro_roteador.sv
// Round-robin arbiter for two requesters sharing a 2:1 routing datapath.
// Winner's word passes through a single-entry output register with valid/ready.
module arbitro_roteador #(
   parameter int WIDTH     = 4,
   parameter int MAX_BURST = 4
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             req_a,
   input  logic [WIDTH-1:0] data_a,
   input  logic             lock_a,
   input  logic             req_b,
   input  logic [WIDTH-1:0] data_b,
   input  logic             lock_b,
   output logic             ack_a,
   output logic             ack_b,
   output logic             sel,
   input  logic             out_ready,
   output logic             out_valid,
   output logic [WIDTH-1:0] out_data
);

   localparam int CW = $clog2(MAX_BURST + 1);
   localparam logic [CW:0] BURST_LIM = (CW+1)'(MAX_BURST);

   typedef enum logic [1:0] {IDLE, SERVE_A, SERVE_B} state_t;

   state_t         state;
   logic           last;     // 0 = A served last, 1 = B served last
   logic [CW-1:0]  count;
   logic           space;
   logic           take;
   logic           owner_req;
   logic           owner_lock;
   logic           keep_lock;
   logic [CW:0]    count_nxt;
   logic [WIDTH-1:0] routed;

   assign space = !out_valid || out_ready;

   // Acks are combinational so the requester sees consumption in the same cycle.
   assign ack_a = !reset && (state == SERVE_A) && req_a && space;
   assign ack_b = !reset && (state == SERVE_B) && req_b && space;
   assign take  = ack_a || ack_b;

   assign routed     = sel ? data_b : data_a;
   assign owner_req  = (state == SERVE_B) ? req_b  : req_a;
   assign owner_lock = (state == SERVE_B) ? lock_b : lock_a;
   assign count_nxt  = {1'b0, count} + {{CW{1'b0}}, 1'b1};
   assign keep_lock  = owner_lock && (count_nxt < BURST_LIM);

   always_ff @(posedge clock) begin
      if (reset) begin
         state     <= IDLE;
         last      <= 1'b1;
         count     <= '0;
         sel       <= 1'b0;
         out_valid <= 1'b0;
         out_data  <= '0;
      end else begin
         if (take) begin
            out_data  <= routed;
            out_valid <= 1'b1;
         end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
         end

         case (state)
            IDLE: begin
               if (req_a && (!req_b || last)) begin
                  state <= SERVE_A;
                  sel   <= 1'b0;
                  count <= '0;
               end else if (req_b) begin
                  state <= SERVE_B;
                  sel   <= 1'b1;
                  count <= '0;
               end
            end
            SERVE_A, SERVE_B: begin
               if (!owner_req) begin
                  state <= IDLE;
                  sel   <= 1'b0;
                  last  <= (state == SERVE_B);
               end else if (space) begin
                  // A stall (no space) leaves count untouched.
                  count <= count_nxt[CW-1:0];
                  if (!keep_lock) begin
                     state <= IDLE;
                     sel   <= 1'b0;
                     last  <= (state == SERVE_B);
                  end
               end
            end
            default: begin
               state <= IDLE;
               sel   <= 1'b0;
            end
         endcase
      end
   end

endmodule
